gfx_bus_master: RTL and testbench
=================================

Name: gfx_bus_master

Overview:
- Host-side initiator for the graphics adapter's chip-select register bus: cs, rs, wren, 8-bit data and the 1 MHz-style strobe.
- Accepts register read/write commands on a valid/ready interface and buffers them in a small FIFO.
- Sequences each command as a timed bus cycle and returns read data on a response strobe.
- Drives the adapter from a soft CPU or a test harness in the same FPGA.

Parameters:
- SETUP_CYC, 2, clk cycles with cs low and strobe low before the strobe; 1..15.
- STROBE_CYC, 4, clk cycles with strobe high; 1..15.
- HOLD_CYC, 2, clk cycles with cs low after the strobe falls; 1..15.
- FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock; the single clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_write  in  1  1 = register write, 0 = register read.
- cmd_rs  in  4  register select.
- cmd_data  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse; read data valid.
- rsp_data  out  8  read data, held until the next read.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- bus_cs_n  out  1  chip select, active low.
- bus_rs  out  4  register select.
- bus_wren_n  out  1  write enable, active low.
- bus_strobe  out  1  external clock/strobe to the adapter.
- bus_data_o  out  8  data driven to the bus.
- bus_data_oe  out  1  tristate enable; the top level builds the inout.
- bus_data_i  in  8  data sampled from the bus.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: cs_n=1, wren_n=1, strobe=0, oe=0, rs=0, data_o=0, rsp_valid=0, rsp_data=0, FIFO empty, FSM IDLE.
- Reset asserted mid-transaction releases the bus at the next edge. The in-flight command and all queued commands are dropped.
- Handshake: cmd_ready = !full, combinational from the current count. A push occurs when cmd_valid && cmd_ready.
  - A simultaneous push and pop while full is not allowed: ready is low.
  - A simultaneous push and pop otherwise keeps the count unchanged.
- FSM states IDLE, SETUP, STROBE, HOLD; 4-bit phase counter.
  - IDLE: cs_n=1, oe=0. If the FIFO is non-empty, pop and latch {write, rs, data}, then go to SETUP.
  - The minimum cs_n-high gap between transactions is 1 cycle.
  - SETUP: cs_n=0, rs=latched, wren_n=!write, oe=write, data_o=latched. Stays SETUP_CYC cycles, then STROBE.
  - STROBE: strobe=1 for STROBE_CYC cycles; other outputs as in SETUP.
    - On a read, bus_data_i is sampled at the clock edge ending the last STROBE cycle into rsp_data.
    - rsp_valid is high for exactly the first HOLD cycle.
  - HOLD: strobe=0, cs_n/rs/wren_n/oe/data_o unchanged for HOLD_CYC cycles, then IDLE.
- Read turnaround: oe is never asserted during a read transaction.
- cs_n low duration = SETUP_CYC+STROBE_CYC+HOLD_CYC. Defaults: 8 cycles, strobe in cycles 3-6 of cs_n low.
- Latency: a command pushed at edge N into an empty FIFO in IDLE is popped at edge N+1, and cs_n falls after edge N+1.
- There is no response backpressure; a missed rsp_valid is lost.
- Counter comparisons use phase == CYC-1. A CYC parameter of 0 is illegal and is rejected by an elaboration-time check.

Optional Feature:
- Macro: GFXBUS_STATS_EN.
- When defined, adds outputs stat_wr_cnt[15:0] and stat_rd_cnt[15:0].
  - Each increments on entry to HOLD of the matching transaction type.
  - Both wrap at 0xFFFF→0 and reset to 0.
- When undefined, these ports and counters do not exist. Core timing is identical either way.

Decomposition:
- Shared package gfx_bus_pkg holds:
  - the FSM state typedef;
  - register index constants (REG_MODE=0, REG_DATA=1, REG_ADDR_LO=3, REG_ADDR_HI=4, REG_CMD=5);
  - the command struct {write, rs, data}.
- One sub-module: gfx_bus_cmd_fifo, a synchronous FIFO of 13-bit entries with full/empty/count.

Test Plan:
- Write rs=1 data=0x41 after reset: cs_n low 8 cycles; strobe high in cycles 3-6; wren_n=0, oe=1, data_o=0x41, rs=1 throughout; then busy drops.
- Read rs=1 with bus_data_i=0x5A during strobe: oe=0 throughout; rsp_valid pulses once in the first HOLD cycle; rsp_data=0x5A persists afterwards.
- Push 5 writes back-to-back with default depth 4 while the first is executing: cmd_ready falls when the FIFO is full; all 5 issue in order with exactly 1 idle cycle of cs_n=1 between them.
- Write then read to rs=3/rs=3: no cycle has oe=1 while wren_n=1; rsp_data equals the bus value at the last strobe edge.
- Assert rst_n=0 during the STROBE of a write with 2 queued: the next edge gives cs_n=1, strobe=0, oe=0, FIFO empty; after release, no queued command issues.
- With GFXBUS_STATS_EN: 3 writes and 2 reads give stat_wr_cnt=3 and stat_rd_cnt=2; preload to 0xFFFF via forced wrap of 65536 writes and check it reaches 0.

Source files
------------

// File: rtl/gfx_bus_pkg.sv
// Shared types and constants for the graphics adapter register-bus master.
// Used by gfx_bus_master, gfx_bus_cmd_fifo and the bench.
package gfx_bus_pkg;

    localparam int unsigned RS_W   = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CMD_W  = 1 + RS_W + DATA_W;

    // Adapter register map.
    localparam logic [RS_W-1:0] REG_MODE    = 4'd0;
    localparam logic [RS_W-1:0] REG_DATA    = 4'd1;
    localparam logic [RS_W-1:0] REG_ADDR_LO = 4'd3;
    localparam logic [RS_W-1:0] REG_ADDR_HI = 4'd4;
    localparam logic [RS_W-1:0] REG_CMD     = 4'd5;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } bus_state_e;

    typedef struct packed {
        logic              write;
        logic [RS_W-1:0]   rs;
        logic [DATA_W-1:0] data;
    } bus_cmd_t;

    // Terminal value of the 4-bit phase counter for a phase lasting cyc cycles.
    function automatic logic [3:0] phase_last(input int unsigned cyc);
        return 4'(cyc - 1);
    endfunction

endpackage

// File: rtl/gfx_bus_cmd_fifo.sv
// Synchronous command FIFO with full/empty/count; power-of-two depth so the
// pointers wrap naturally.
module gfx_bus_cmd_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned   PtrW     = $clog2(Depth);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Overflowing pushes and underflowing pops are ignored.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/gfx_bus_master.sv
// Host-side initiator for the adapter's chip-select register bus: buffers commands and
// runs each as a SETUP/STROBE/HOLD cycle. Define GFXBUS_STATS_EN for write/read counters.
module gfx_bus_master
    import gfx_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [RS_W-1:0]   cmd_rs,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
`ifdef GFXBUS_STATS_EN
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_rd_cnt,
`endif
    output logic              busy,
    output logic              bus_cs_n,
    output logic [RS_W-1:0]   bus_rs,
    output logic              bus_wren_n,
    output logic              bus_strobe,
    output logic [DATA_W-1:0] bus_data_o,
    output logic              bus_data_oe,
    input  logic [DATA_W-1:0] bus_data_i
);

    if (SETUP_CYC == 0 || SETUP_CYC > 15) begin : g_bad_setup
        $error("SETUP_CYC must be in 1..15");
    end
    if (STROBE_CYC == 0 || STROBE_CYC > 15) begin : g_bad_strobe
        $error("STROBE_CYC must be in 1..15");
    end
    if (HOLD_CYC == 0 || HOLD_CYC > 15) begin : g_bad_hold
        $error("HOLD_CYC must be in 1..15");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end

    localparam int unsigned CntW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0]  SetupLast  = phase_last(SETUP_CYC);
    localparam logic [3:0]  StrobeLast = phase_last(STROBE_CYC);
    localparam logic [3:0]  HoldLast   = phase_last(HOLD_CYC);

    bus_state_e        state_q, state_d;
    logic [3:0]        phase_q, phase_d;
    bus_cmd_t          cmd_q, cmd_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    bus_cmd_t          fifo_wdata;
    logic [CMD_W-1:0]  fifo_rdata;
    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic              strobe_last;

    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_wdata = '{write: cmd_write, rs: cmd_rs, data: cmd_data};

    gfx_bus_cmd_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (CMD_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Last STROBE cycle: the following edge samples read data and enters HOLD.
    assign strobe_last = (state_q == StStrobe) && (phase_q == StrobeLast);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            cmd_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cmd_q      <= cmd_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cmd_d      = cmd_q;
        rsp_data_d = rsp_data_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = bus_cmd_t'(fifo_rdata);
                    phase_d  = '0;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                if (phase_q == SetupLast) begin
                    phase_d = '0;
                    state_d = StStrobe;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StStrobe: begin
                if (strobe_last) begin
                    phase_d = '0;
                    state_d = StHold;
                    if (!cmd_q.write) begin
                        rsp_data_d = bus_data_i;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StHold: begin
                if (phase_q == HoldLast) begin
                    phase_d = '0;
                    state_d = StIdle;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            default: begin
                phase_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Address/data stay on the bus after a cycle; only the controls are released.
    always_comb begin
        bus_cs_n    = 1'b1;
        bus_wren_n  = 1'b1;
        bus_data_oe = 1'b0;
        bus_strobe  = 1'b0;
        rsp_valid   = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StSetup, StStrobe, StHold: begin
                bus_cs_n    = 1'b0;
                bus_wren_n  = !cmd_q.write;
                bus_data_oe = cmd_q.write;
                bus_strobe  = (state_q == StStrobe);
                rsp_valid   = (state_q == StHold) && (phase_q == '0) && !cmd_q.write;
            end
            default: begin
            end
        endcase
    end

    assign bus_rs     = cmd_q.rs;
    assign bus_data_o = cmd_q.data;
    assign rsp_data   = rsp_data_q;
    assign busy       = (fifo_count != '0) || (state_q != StIdle);

`ifdef GFXBUS_STATS_EN
    logic [15:0] stat_wr_q, stat_rd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else if (strobe_last) begin
            if (cmd_q.write) begin
                stat_wr_q <= stat_wr_q + 16'd1;
            end else begin
                stat_rd_q <= stat_rd_q + 16'd1;
            end
        end
    end

    assign stat_wr_cnt = stat_wr_q;
    assign stat_rd_cnt = stat_rd_q;
`endif

endmodule

// File: tb/tb_gfx_bus_master.sv
// Scoreboard bench for gfx_bus_master: stimulus queues expected bus cycles, a monitor
// reconstructs each cs_n-low window and checks it. Stats checks need GFXBUS_STATS_EN.
module tb_gfx_bus_master;
    import gfx_bus_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [3:0] cmd_rs = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, rsp_valid, busy;
    logic [7:0] rsp_data;
    logic       bus_cs_n, bus_wren_n, bus_strobe, bus_data_oe;
    logic [3:0] bus_rs;
    logic [7:0] bus_data_o;
    logic [7:0] bus_data_i = '0;
`ifdef GFXBUS_STATS_EN
    logic [15:0] stat_wr_cnt, stat_rd_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       write;
        logic [3:0] rs;
        logic [7:0] data;
        bit         gap_chk;
    } exp_t;
    exp_t exp_q[$];

    bit         bus_vary = 1'b0;
    logic [7:0] bus_static = '0;

    gfx_bus_master dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_rs      (cmd_rs),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
`ifdef GFXBUS_STATS_EN
        .stat_wr_cnt (stat_wr_cnt),
        .stat_rd_cnt (stat_rd_cnt),
`endif
        .busy        (busy),
        .bus_cs_n    (bus_cs_n),
        .bus_rs      (bus_rs),
        .bus_wren_n  (bus_wren_n),
        .bus_strobe  (bus_strobe),
        .bus_data_o  (bus_data_o),
        .bus_data_oe (bus_data_oe),
        .bus_data_i  (bus_data_i)
    );

    always #5 clk = ~clk;

    // Adapter side of the data bus: a fixed value or one that changes every cycle.
    always @(posedge clk) begin
        #1;
        bus_data_i = bus_vary ? bus_data_i + 8'h17 : bus_static;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor state for the current cs_n-low window.
    bit          in_txn = 1'b0;
    int          idx, gap = 100, gap_before;
    logic [31:0] smask;
    logic        f_wren, f_oe;
    logic [3:0]  f_rs;
    logic [7:0]  f_data, samp, rsp_seen;
    int          const_bad, oe_bad, rsp_cnt, rsp_idx;

    task automatic finish_txn();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn_unexpected: got rs=0x%0h, expected no transaction", f_rs);
            return;
        end
        e = exp_q.pop_front();
        check("cs_low_len", idx, 8);
        check("strobe_pos", smask, 32'h0000_003C);
        check("wren_n", f_wren, !e.write);
        check("oe", f_oe, e.write);
        check("rs", f_rs, e.rs);
        if (e.write) check("data_o", f_data, e.data);
        check("held_const", const_bad, 0);
        check("oe_without_wren", oe_bad, 0);
        if (e.gap_chk) check("cs_gap", gap_before, 1);
        if (e.write) begin
            check("wr_no_rsp", rsp_cnt, 0);
        end else begin
            check("rsp_count", rsp_cnt, 1);
            check("rsp_cycle", rsp_idx, 6);
            check("rsp_data", rsp_seen, samp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_txn = 1'b0;
            gap    = 100;
        end else if (!bus_cs_n) begin
            if (!in_txn) begin
                in_txn     = 1'b1;
                idx        = 0;
                gap_before = gap;
                smask      = '0;
                f_wren     = bus_wren_n;
                f_oe       = bus_data_oe;
                f_rs       = bus_rs;
                f_data     = bus_data_o;
                const_bad  = 0;
                oe_bad     = 0;
                rsp_cnt    = 0;
                rsp_idx    = 0;
                rsp_seen   = '0;
                samp       = '0;
            end
            if (idx < 32) smask[idx] = bus_strobe;
            if (bus_wren_n !== f_wren || bus_data_oe !== f_oe ||
                bus_rs !== f_rs || bus_data_o !== f_data) const_bad++;
            if (bus_data_oe && bus_wren_n) oe_bad++;
            // cs-low cycle 6 is the last strobe cycle at default timing.
            if (idx == 5) samp = bus_data_i;
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_idx  = idx;
                rsp_seen = rsp_data;
            end
            idx++;
        end else begin
            if (in_txn) begin
                finish_txn();
                gap = 0;
            end
            in_txn = 1'b0;
            gap++;
        end
    end

    task automatic push_cmd(input logic w, input logic [3:0] rs, input logic [7:0] d,
                            input bit gchk);
        exp_t e;
        int   k;
        @(negedge clk);
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: got cmd_ready=0, expected 1 within 200 cycles");
            return;
        end
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_rs    = rs;
        cmd_data  = d;
        e.write   = w;
        e.rs      = rs;
        e.data    = d;
        e.gap_chk = gchk;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy && bus_cs_n) break;
        end
        check(name, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", bus_cs_n, 1);
        check("rst_wren_n", bus_wren_n, 1);
        check("rst_strobe", bus_strobe, 0);
        check("rst_oe", bus_data_oe, 0);
        check("rst_rs", bus_rs, 0);
        check("rst_data_o", bus_data_o, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;

        // Single write, with pop latency.
        push_cmd(1'b1, REG_DATA, 8'h41, 1'b0);
        @(negedge clk);
        check("lat_cs_still_high", bus_cs_n, 1);
        check("busy_after_push", busy, 1);
        @(negedge clk);
        check("lat_cs_low", bus_cs_n, 0);
        wait_idle("wr_idle");

        // Single read of a fixed bus value.
        bus_static = 8'h5A;
        push_cmd(1'b0, REG_DATA, 8'h00, 1'b0);
        wait_idle("rd_idle");
        check("rd_value", rsp_data, 8'h5A);
        repeat (5) @(negedge clk);
        check("rd_value_held", rsp_data, 8'h5A);

        // Write then read of the same register while the bus value keeps moving.
        bus_vary = 1'b1;
        push_cmd(1'b1, REG_ADDR_LO, 8'h9C, 1'b0);
        push_cmd(1'b0, REG_ADDR_LO, 8'h00, 1'b1);
        wait_idle("wr_rd_idle");
        check("rd_last_strobe_value", rsp_data, samp);

        // Five back-to-back writes into a depth-4 FIFO.
        for (int i = 0; i < 5; i++) begin
            push_cmd(1'b1, 4'(i + 2), 8'(8'h10 + i), i != 0);
        end
        @(negedge clk);
        check("full_ready_low", cmd_ready, 0);
        check("full_busy", busy, 1);
        wait_idle("burst_idle");
        check("burst_ready_back", cmd_ready, 1);

`ifdef GFXBUS_STATS_EN
        check("stat_wr_7", stat_wr_cnt, 7);
        check("stat_rd_2", stat_rd_cnt, 2);
`endif

        // Reset during the strobe of a write with two queued behind it.
        bus_vary = 1'b0;
        push_cmd(1'b1, REG_CMD, 8'hA5, 1'b0);
        push_cmd(1'b1, REG_MODE, 8'h01, 1'b1);
        push_cmd(1'b1, REG_ADDR_HI, 8'h02, 1'b1);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus_strobe) break;
        end
        check("strobe_seen", bus_strobe, 1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("mid_rst_cs_n", bus_cs_n, 1);
        check("mid_rst_strobe", bus_strobe, 0);
        check("mid_rst_oe", bus_data_oe, 0);
        check("mid_rst_wren_n", bus_wren_n, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (!bus_cs_n) lows++;
        end
        check("no_issue_after_rst", lows, 0);

`ifdef GFXBUS_STATS_EN
        check("stat_wr_rst", stat_wr_cnt, 0);
        check("stat_rd_rst", stat_rd_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            push_cmd(i < 3, REG_DATA, 8'(i), 1'b0);
        end
        wait_idle("stat_idle");
        check("stat_wr_3", stat_wr_cnt, 3);
        check("stat_rd_2b", stat_rd_cnt, 2);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
